fb_pixel_writer: RTL and testbench

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

---
 rtl/fb_pkg.sv | 31 +++
 rtl/pixel_fifo.sv | 60 ++++++
 rtl/fb_pixel_writer.sv | 123 ++++++++++++
 tb/tb_fb_pixel_writer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants, state encoding and pixel payload type.
package fb_pkg;

  localparam int unsigned H_RES     = 320;
  localparam int unsigned V_RES     = 240;
  localparam int unsigned FB_PIXELS = H_RES * V_RES;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned COLOR_W   = 12;
  localparam int unsigned X_W       = 9;
  localparam int unsigned Y_W       = 8;
  localparam int unsigned PIX_W     = ADDR_W + COLOR_W;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_WAIT = 2'd1,
    ST_CLEAR      = 2'd2,
    ST_CLEAR_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } pix_t;

  // Row stride of 320 expressed as y*256 + y*64, computed at full address width.
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return (ADDR_W'(y) << 8) + (ADDR_W'(y) << 6) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO buffering accepted pixels ahead of the framebuffer port.
module pixel_fifo #(
  parameter int unsigned WIDTH = 29,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign head      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Buffers draw-module pixels into framebuffer writes and performs full-screen fills.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned H_RES      = fb_pkg::H_RES,
  parameter int unsigned V_RES      = fb_pkg::V_RES,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [X_W-1:0]     X_in,
  input  logic [Y_W-1:0]     Y_in,
  input  logic [COLOR_W-1:0] Color_in,
  input  logic               writeEn_in,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  input  logic               fb_ready,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               fb_we,
  output logic               sink_full,
  output logic               overflow,
  output logic               clear_done,
  output logic               busy
);

  localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(H_RES * V_RES - 1);

  state_t             r_state;
  logic [ADDR_W-1:0]  r_fill;
  logic [COLOR_W-1:0] r_clear_color;
  logic               r_overflow;

  pix_t               w_push_pix;
  pix_t               w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_in_range;
  logic               w_pixel_ok;
  logic               w_push;
  logic               w_drain;
  logic               w_pop;

  assign w_in_range = (32'(X_in) < H_RES) && (32'(Y_in) < V_RES);
  assign w_pixel_ok = (r_state == ST_IDLE) && writeEn_in && w_in_range;
  // Fullness is the pre-edge value, so a simultaneous pop never makes room.
  assign w_push     = w_pixel_ok && !w_full;
  assign w_drain    = ((r_state == ST_IDLE) || (r_state == ST_CLEAR_WAIT)) && !w_empty;
  assign w_pop      = w_drain && fb_ready;
  assign w_push_pix = '{addr: pix_addr(X_in, Y_in), color: Color_in};

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_pix),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Framebuffer port: queued pixels take priority, fill writes only in CLEAR.
  always_comb begin
    fb_we   = 1'b0;
    fb_addr = '0;
    fb_data = '0;
    if (w_drain) begin
      fb_we   = 1'b1;
      fb_addr = w_head.addr;
      fb_data = w_head.color;
    end else if (r_state == ST_CLEAR) begin
      fb_we   = 1'b1;
      fb_addr = r_fill;
      fb_data = r_clear_color;
    end
  end

  assign sink_full  = (w_count == CNT_W'(FIFO_DEPTH));
  assign overflow   = r_overflow;
  assign clear_done = (r_state == ST_CLEAR_DONE);
  assign busy       = (r_state != ST_IDLE) || !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_fill        <= '0;
      r_clear_color <= '0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_pixel_ok && w_full) r_overflow <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state       <= ST_CLEAR_WAIT;
            r_clear_color <= clear_color;
          end
        end
        ST_CLEAR_WAIT: begin
          if (w_empty) r_state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (fb_ready) begin
            if (r_fill == FILL_LAST) r_state <= ST_CLEAR_DONE;
            else                     r_fill  <= r_fill + ADDR_W'(1);
          end
        end
        ST_CLEAR_DONE: begin
          r_fill  <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer.
module tb_fb_pixel_writer;

  logic        clk;
  logic        reset;
  logic [8:0]  X_in;
  logic [7:0]  Y_in;
  logic [11:0] Color_in;
  logic        writeEn_in;
  logic        clear_req;
  logic [11:0] clear_color;
  logic        fb_ready;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic        fb_we;
  logic        sink_full;
  logic        overflow;
  logic        clear_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  logic [16:0] wa_q[$];
  logic [11:0] wd_q[$];

  fb_pixel_writer #(
    .H_RES      (320),
    .V_RES      (240),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .X_in        (X_in),
    .Y_in        (Y_in),
    .Color_in    (Color_in),
    .writeEn_in  (writeEn_in),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .fb_ready    (fb_ready),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .sink_full   (sink_full),
    .overflow    (overflow),
    .clear_done  (clear_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write the framebuffer will accept on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && fb_we && fb_ready) begin
      wa_q.push_back(fb_addr);
      wd_q.push_back(fb_data);
    end
    if (clear_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pixel_edge(input logic [8:0] x, input logic [7:0] y, input logic [11:0] c);
    X_in = x; Y_in = y; Color_in = c; writeEn_in = 1'b1;
    @(posedge clk);
    #1 writeEn_in = 1'b0;
  endtask

  initial begin
    int bad;
    int base_done;
    bit found;
    reset = 1'b1; X_in = '0; Y_in = '0; Color_in = '0; writeEn_in = 1'b0;
    clear_req = 1'b0; clear_color = '0; fb_ready = 1'b1;
    #12;
    check("rst_we",       32'(fb_we), 0);
    check("rst_addr",     32'(fb_addr), 0);
    check("rst_data",     32'(fb_data), 0);
    check("rst_full",     32'(sink_full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_done",     32'(clear_done), 0);
    check("rst_busy",     32'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Single pixel: visible the cycle after the accepting edge.
    pixel_edge(9'd5, 8'd2, 12'hF00);
    @(negedge clk);
    check("px_we",   32'(fb_we), 1);
    check("px_addr", 32'(fb_addr), 645);
    check("px_data", 32'(fb_data), 32'hF00);
    @(negedge clk);
    check("px_we_gone", 32'(fb_we), 0);

    // Bottom-right corner.
    @(posedge clk); #1;
    pixel_edge(9'd319, 8'd239, 12'h0A5);
    @(negedge clk);
    check("corner_addr", 32'(fb_addr), 76799);
    check("corner_data", 32'(fb_data), 32'h0A5);

    // Out-of-range column.
    @(posedge clk); #1;
    pixel_edge(9'd320, 8'd0, 12'h111);
    @(negedge clk);
    check("oor_we",       32'(fb_we), 0);
    check("oor_overflow", 32'(overflow), 0);
    check("oor_busy",     32'(busy), 0);

    // Back-pressure: 6 pixels into a 4-deep FIFO.
    @(posedge clk); #1;
    fb_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      X_in = 9'(i); Y_in = 8'd1; Color_in = 12'h100 + 12'(i); writeEn_in = 1'b1;
      @(posedge clk); #1;
    end
    writeEn_in = 1'b0;
    @(negedge clk);
    check("bp_full",     32'(sink_full), 1);
    check("bp_overflow", 32'(overflow), 1);
    check("bp_we_held",  32'(fb_we), 1);
    check("bp_head",     32'(fb_addr), 320);
    @(posedge clk); #1;
    wa_q.delete(); wd_q.delete();
    fb_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("bp_nwrites", 32'(wa_q.size()), 4);
    if (wa_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("bp_order_addr", 32'(wa_q[i]), 320 + i);
        check("bp_order_data", 32'(wd_q[i]), 32'h100 + i);
      end
    end
    check("bp_full_clr",   32'(sink_full), 0);
    check("bp_sticky_ovf", 32'(overflow), 1);

    // Full-screen fill with two pixels still queued.
    do_reset();
    check("ovf_cleared", 32'(overflow), 0);
    fb_ready = 1'b0;
    pixel_edge(9'd10, 8'd0, 12'hABC);
    pixel_edge(9'd0,  8'd1, 12'h123);
    wa_q.delete(); wd_q.delete(); done_cnt = 0;
    clear_req = 1'b1; clear_color = 12'h00F;
    @(posedge clk); #1;
    clear_req = 1'b0; clear_color = 12'hFFF;
    check("wait_busy", 32'(busy), 1);
    fb_ready = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) pixel_edge(9'(20 + i), 8'd3, 12'h777);
    for (int i = 0; i < 80000 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("fill_done_cnt", 32'(done_cnt), 1);
    check("fill_nwrites",  32'(wa_q.size()), 76802);
    if (wa_q.size() >= 2) begin
      check("fill_px0_addr", 32'(wa_q[0]), 10);
      check("fill_px0_data", 32'(wd_q[0]), 32'hABC);
      check("fill_px1_addr", 32'(wa_q[1]), 320);
      check("fill_px1_data", 32'(wd_q[1]), 32'h123);
    end
    bad = 0;
    for (int j = 2; j < wa_q.size(); j++) begin
      if (wa_q[j] !== 17'(j - 2) || wd_q[j] !== 12'h00F) bad++;
    end
    check("fill_sequence", 32'(bad), 0);
    check("fill_overflow", 32'(overflow), 0);
    check("fill_busy",     32'(busy), 0);
    check("fill_we_idle",  32'(fb_we), 0);

    // Reset in the middle of a fill.
    clear_req = 1'b1; clear_color = 12'h0F0;
    @(posedge clk); #1;
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (fb_we && fb_addr == 17'd1000) found = 1'b1;
    end
    check("rc_reached_1000", 32'(found), 1);
    check("rc_data",         32'(fb_data), 32'h0F0);
    base_done = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("rc_we_now",   32'(fb_we), 0);
    check("rc_addr_now", 32'(fb_addr), 0);
    check("rc_busy_now", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rc_busy",    32'(busy), 0);
    check("rc_we",      32'(fb_we), 0);
    check("rc_no_done", 32'(done_cnt - base_done), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
